// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared FSM encoding and return-FIFO depth for the BRAM stream reader.
package bram_stream_reader_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/bram_stream_reader_stream_fifo2.sv
// stream_fifo2: 2-entry registered FIFO holding BRAM read returns.
// Ports: clock_i/reset_i (async high), push_i/data_i write side, pop_i read side,
// count_o occupancy, head_o oldest word (0 when empty).
module stream_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o
);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_q, rd_q;
  logic [1:0]            count_q;
  // storage is deliberately not reset; only pointers and count are
  always_ff @(posedge clock_i)
    if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i) rd_q <= ~rd_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  assign count_o = count_q;
  assign head_o  = count_q != 2'd0 ? mem_q[rd_q] : '0;
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads length consecutive BRAM words from base_addr and streams them out.
// Ports: clock_i/reset_i (async high); start_i/base_addr_i/length_i command; busy_o/done_o status;
// ram_read_enable_o/ram_read_address_o/ram_read_data_i BRAM read port (1-cycle latency);
// out_valid_o/out_ready_i/out_data_o/out_last_o output stream.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_read_enable_o,
  output logic [ADDR_WIDTH-1:0] ram_read_address_o,
  input  logic [DATA_WIDTH-1:0] ram_read_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o
);
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, issue_q, beat_q;
  logic                  inflight_q, pop, issue;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  stream_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (ram_read_data_i),
    .count_o (fifo_count),
    .head_o  (out_data_o)
  );
  assign out_valid_o = fifo_count != 2'd0;
  assign pop         = out_valid_o & out_ready_i;
  // words owned by the reader after this cycle's pop; a new read only fits if that is below 2
  assign occupancy   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue       = state_q == S_RUN && issue_q < len_q && occupancy < 3'd2;
  assign addr_d      = issue ? base_q + issue_q[ADDR_WIDTH-1:0] : addr_q;
  assign ram_read_enable_o  = issue;
  assign ram_read_address_o = addr_d;
  // the head word is always the next beat, so its index equals beat_q
  assign out_last_o  = out_valid_o && beat_q == len_q - 1'b1;
  assign busy_o      = state_q == S_RUN || state_q == S_DRAIN;
  assign done_o      = state_q == S_DONE;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      inflight_q <= issue;
      if (issue) issue_q <= issue_q + 1'b1;
      if (pop) beat_q <= beat_q + 1'b1;
      case (state_q)
        S_IDLE:
          if (start_i) begin
            base_q  <= base_addr_i;
            len_q   <= length_i;
            issue_q <= '0;
            beat_q  <= '0;
            state_q <= length_i != '0 ? S_RUN : S_DONE;
          end
        S_RUN:   if (issue_q == len_q) state_q <= S_DRAIN;
        S_DRAIN: if (pop && out_last_o) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
      endcase
    end
endmodule
